daq_rdclk_burst: RTL and testbench
==================================

# daq_rdclk_burst

Programmable read-clock burst generator for the DAQ ADC readout path, successor to the fixed-ratio read clock divider. On a start request it emits a burst of N read-clock pulses whose high and low phase lengths are set at run time, reports progress and completion, and optionally free-runs. It sits between the acquisition sequencer (start/abort, counts) and the ADC read-strobe pins (clk_o / clk_en_o).

## Interface
- CNT_W, 8: width of high/low phase length inputs and phase counter.
- BURST_W, 8: width of burst length input and pulse counter.
- clk_i  in  1  system clock (200 MHz nominal).
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  start request; sampled only in IDLE.
- abort_i  in  1  synchronous abort; overrides all other inputs.
- free_run_i  in  1  1 = repeat pulses until deasserted; burst_len_i ignored.
- high_cnt_i  in  CNT_W  high-phase length in clk_i cycles (0 treated as 1).
- low_cnt_i  in  CNT_W  low-phase length in clk_i cycles (0 treated as 1).
- burst_len_i  in  BURST_W  pulses per burst.
- en_i  in  1  output gate for clk_en_o.
- clk_o  out  1  registered read clock.
- clk_en_o  out  1  en_i ? clk_o : 1 (combinational).
- edge_o  out  1  registered; high in the first cycle of every high phase.
- busy_o  out  1  registered; high while in HIGH or LOW.
- done_o  out  1  registered one-cycle completion strobe.
- pulse_cnt_o  out  BURST_W  completed high phases in current burst; wraps at 2^BURST_W in free-run.

## Operation
- States: IDLE, HIGH, LOW. Reset: state IDLE; clk_o, edge_o, busy_o, done_o = 0; pulse_cnt_o = 0; phase counter 0; latched counts 0.
- IDLE: on start_i=1, latch high_cnt_i, low_cnt_i, burst_len_i, free_run mode; clear pulse_cnt_o.
  - If free_run_i=0 and burst_len_i=0: stay IDLE, done_o=1 next cycle, no pulse.
  - Otherwise go HIGH.
- HIGH: clk_o=1 for exactly H cycles (H = latched high, min 1); edge_o=1 in first cycle only. On leaving, pulse_cnt_o increments by 1; go LOW.
- LOW: clk_o=0 for exactly L cycles (L = latched low, min 1). At end of phase:
  - free-run mode and free_run_i=1 (live input): go HIGH.
  - burst mode and pulse_cnt_o < latched burst length: go HIGH.
  - else: go IDLE, done_o=1 for one cycle.
- Free-run exit: deasserting free_run_i never truncates a phase; current HIGH+LOW period completes, then done_o.
- Phase lengths and burst length are latched at start; changes to high_cnt_i/low_cnt_i/burst_len_i mid-burst have no effect.
- start_i while busy_o=1 is ignored (no restart, no queue).
- abort_i=1 in any state: next cycle IDLE, clk_o=0, edge_o=0, busy_o=0, done_o=0, pulse_cnt_o holds its value. abort_i with start_i in IDLE: abort wins, no burst.
- clk_en_o follows en_i and clk_o combinationally; en_i=0 forces 1 regardless of state or reset.

## Timing
- start_i sampled at edge N: clk_o=1, edge_o=1, busy_o=1 from edge N+1.
- Period = H+L cycles; duty exact, no gap cycles between LOW and next HIGH.
- Burst of P pulses: clk_o high for the H cycles beginning N+1+k(H+L), k=0..P-1; busy_o high N+1 through N+P(H+L); done_o high at cycle N+P(H+L)+1 with busy_o=0.
- Back-to-back: start_i may be asserted in the done_o cycle (state IDLE) and is accepted; next burst clk_o rises one cycle later.
- Reset asserted mid-burst: all registered outputs go to reset values immediately (asynchronous); operation resumes only on a new start_i after reset release.
- pulse_cnt_o updates in the cycle clk_o falls.

## Test plan
- Reset values: assert reset_i mid-HIGH with H=5 -> clk_o, busy_o, edge_o, done_o, pulse_cnt_o all 0 same cycle; en_i=0 -> clk_en_o=1.
- Basic burst: H=2, L=3, P=4, start at N -> clk_o high N+1..N+2, N+6..N+7, N+11..N+12, N+16..N+17; done_o at N+21; pulse_cnt_o=4; 4 edge_o strobes.
- Zero handling: H=0, L=0, P=3 -> 1-high/1-low square wave, 3 pulses, done_o at N+7; P=0 -> no pulse, done_o at N+1, busy_o stays 0.
- Free-run: H=1, L=1, drop free_run_i in a HIGH cycle after 300 pulses -> current period completes, done_o next, pulse_cnt_o = 301 mod 256 = 45.
- Abort and ignored start: start P=10, pulse start_i again at pulse 2 (ignored, count continues), abort_i at pulse 5 -> clk_o=0 and busy_o=0 next cycle, no done_o, pulse_cnt_o holds 4 or 5 per phase.
- Mid-burst input changes: change high_cnt_i/burst_len_i after start -> waveform matches latched values; start_i in done_o cycle -> new burst begins one cycle later.

Source files
------------

// File: rtl/daq_rdclk_burst.sv
// Programmable read-clock burst generator: emits N read-clock pulses with run-time
// high/low phase lengths, reports progress and completion, and can free-run.
module daq_rdclk_burst #(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               free_run_i,
  input  logic [CNT_W-1:0]   high_cnt_i,
  input  logic [CNT_W-1:0]   low_cnt_i,
  input  logic [BURST_W-1:0] burst_len_i,
  input  logic               en_i,
  output logic               clk_o,
  output logic               clk_en_o,
  output logic               edge_o,
  output logic               busy_o,
  output logic               done_o,
  output logic [BURST_W-1:0] pulse_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ZERO = {BURST_W{1'b0}};
  localparam logic [BURST_W-1:0] BURST_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};

  // The phase counter holds cycles remaining minus one; a zero length behaves as one.
  function automatic logic [CNT_W-1:0] phase_load(input logic [CNT_W-1:0] cnt);
    phase_load = (cnt == CNT_ZERO) ? CNT_ZERO : (cnt - CNT_ONE);
  endfunction

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     phase_q, phase_d;
  logic [CNT_W-1:0]     hi_q, hi_d;
  logic [CNT_W-1:0]     lo_q, lo_d;
  logic [BURST_W-1:0]   burst_q, burst_d;
  logic                 free_q, free_d;
  logic [BURST_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  logic                 clk_q, clk_d;
  logic                 edge_q, edge_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 finish_s;
  logic                 repeat_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      phase_q     <= CNT_ZERO;
      hi_q        <= CNT_ZERO;
      lo_q        <= CNT_ZERO;
      burst_q     <= BURST_ZERO;
      free_q      <= 1'b0;
      pulse_cnt_q <= BURST_ZERO;
      clk_q       <= 1'b0;
      edge_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      burst_q     <= burst_d;
      free_q      <= free_d;
      pulse_cnt_q <= pulse_cnt_d;
      clk_q       <= clk_d;
      edge_q      <= edge_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Free-run follows the live input at each period boundary; burst mode uses the latched length.
  assign repeat_s = free_q ? free_run_i : (pulse_cnt_q < burst_q);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    burst_d     = burst_q;
    free_d      = free_q;
    pulse_cnt_d = pulse_cnt_q;
    finish_s    = 1'b0;
    if (abort_i) begin
      state_d = S_IDLE;
      phase_d = CNT_ZERO;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            hi_d        = high_cnt_i;
            lo_d        = low_cnt_i;
            burst_d     = burst_len_i;
            free_d      = free_run_i;
            pulse_cnt_d = BURST_ZERO;
            if (!free_run_i && (burst_len_i == BURST_ZERO)) begin
              state_d  = S_IDLE;
              finish_s = 1'b1;
            end else begin
              state_d = S_HIGH;
              phase_d = phase_load(high_cnt_i);
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_HIGH: begin
          if (phase_q == CNT_ZERO) begin
            state_d     = S_LOW;
            phase_d     = phase_load(lo_q);
            pulse_cnt_d = pulse_cnt_q + BURST_ONE;
          end else begin
            phase_d = phase_q - CNT_ONE;
          end
        end
        S_LOW: begin
          if (phase_q == CNT_ZERO) begin
            if (repeat_s) begin
              state_d = S_HIGH;
              phase_d = phase_load(hi_q);
            end else begin
              state_d  = S_IDLE;
              finish_s = 1'b1;
            end
          end else begin
            phase_d = phase_q - CNT_ONE;
          end
        end
        default: begin
          state_d = S_IDLE;
          phase_d = CNT_ZERO;
        end
      endcase
    end
  end

  // Registered outputs are decoded from the next state so they align with it.
  always_comb begin
    clk_d  = (state_d == S_HIGH);
    edge_d = (state_d == S_HIGH) && (state_q != S_HIGH);
    busy_d = (state_d != S_IDLE);
    done_d = finish_s;
  end

  assign clk_o       = clk_q;
  assign edge_o      = edge_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pulse_cnt_o = pulse_cnt_q;
  assign clk_en_o    = en_i ? clk_q : 1'b1;

endmodule

// File: tb/tb_daq_rdclk_burst.sv
// Randomized bench for daq_rdclk_burst against an elapsed-time reference model.
module tb_daq_rdclk_burst;

  logic       clk_i, reset_i, start_i, abort_i, free_run_i, en_i;
  logic [7:0] high_cnt_i, low_cnt_i, burst_len_i;
  logic       clk_o, clk_en_o, edge_o, busy_o, done_o;
  logic [7:0] pulse_cnt_o;

  daq_rdclk_burst #(.CNT_W(8), .BURST_W(8)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .start_i(start_i), .abort_i(abort_i),
    .free_run_i(free_run_i), .high_cnt_i(high_cnt_i), .low_cnt_i(low_cnt_i),
    .burst_len_i(burst_len_i), .en_i(en_i), .clk_o(clk_o), .clk_en_o(clk_en_o),
    .edge_o(edge_o), .busy_o(busy_o), .done_o(done_o), .pulse_cnt_o(pulse_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a burst is described by time since start and the period H+L.
  bit   m_act, m_free;
  int   m_t, m_h, m_l, m_p, m_pulses;
  logic [7:0] m_pc;
  logic e_clk, e_edge, e_busy, e_done;

  function automatic void m_reset();
    m_act = 1'b0; m_free = 1'b0; m_t = 0; m_h = 1; m_l = 1; m_p = 0; m_pulses = 0;
    m_pc = 8'd0; e_clk = 1'b0; e_edge = 1'b0; e_busy = 1'b0; e_done = 1'b0;
  endfunction

  function automatic void m_advance();
    int per, p, k;
    bit cont;
    e_done = 1'b0;
    if (abort_i) begin
      m_act = 1'b0;
    end else if (!m_act) begin
      if (start_i) begin
        m_h = (high_cnt_i == 8'd0) ? 1 : int'(high_cnt_i);
        m_l = (low_cnt_i == 8'd0) ? 1 : int'(low_cnt_i);
        m_p = int'(burst_len_i);
        m_free = free_run_i;
        m_pulses = 0;
        m_pc = 8'd0;
        if (!m_free && m_p == 0) e_done = 1'b1;
        else begin m_act = 1'b1; m_t = 1; end
      end
    end else begin
      per = m_h + m_l;
      if (m_t % per == 0) begin
        cont = m_free ? free_run_i : ((m_t / per) < m_p);
        if (cont) m_t++;
        else begin m_act = 1'b0; e_done = 1'b1; end
      end else begin
        m_t++;
      end
    end
    if (m_act) begin
      per = m_h + m_l;
      p = (m_t - 1) % per;
      k = (m_t - 1) / per;
      e_clk = (p < m_h);
      e_edge = (p == 0);
      e_busy = 1'b1;
      m_pulses = k + ((p >= m_h) ? 1 : 0);
      m_pc = m_pulses[7:0];
    end else begin
      e_clk = 1'b0; e_edge = 1'b0; e_busy = 1'b0;
    end
  endfunction

  task automatic compare_outputs();
    chk("clk_o", clk_o, e_clk);
    chk("edge_o", edge_o, e_edge);
    chk("busy_o", busy_o, e_busy);
    chk("done_o", done_o, e_done);
    chk("pulse_cnt_o", pulse_cnt_o, m_pc);
    chk("clk_en_o", clk_en_o, en_i ? e_clk : 1'b1);
  endtask

  task automatic step();
    m_advance();
    @(posedge clk_i);
    #1;
    compare_outputs();
  endtask

  task automatic start_burst(input int h, input int l, input int p, input bit fr);
    high_cnt_i = h[7:0]; low_cnt_i = l[7:0]; burst_len_i = p[7:0]; free_run_i = fr;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic run_until_done(input string tag, input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      step();
      if (!m_act) break;
    end
    chk({tag, "_ended"}, (i < budget), 1'b1);
  endtask

  int edges;
  int i;

  initial begin
    reset_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; free_run_i = 1'b0; en_i = 1'b1;
    high_cnt_i = 8'd0; low_cnt_i = 8'd0; burst_len_i = 8'd0;
    m_reset();
    #2 reset_i = 1'b1;
    #2 compare_outputs();
    @(posedge clk_i); @(posedge clk_i); #1 reset_i = 1'b0;

    // Reset asserted mid-HIGH with H=5
    start_burst(5, 2, 3, 1'b0);
    step();
    chk("pre_reset_clk", clk_o, 1'b1);
    reset_i = 1'b1; en_i = 1'b0;
    #2;
    m_reset();
    compare_outputs();
    chk("rst_clk_en", clk_en_o, 1'b1);
    @(posedge clk_i); #1 reset_i = 1'b0; en_i = 1'b1;
    step(); step();

    // Basic burst H=2 L=3 P=4
    start_burst(2, 3, 4, 1'b0);
    edges = (edge_o === 1'b1) ? 1 : 0;
    for (i = 0; i < 20; i++) begin
      step();
      if (edge_o === 1'b1) edges++;
    end
    chk("basic_done_n21", done_o, 1'b1);
    chk("basic_pc", pulse_cnt_o, 8'd4);
    chk("basic_edges", edges, 4);

    // Zero lengths act as one; zero burst gives only a done strobe
    step();
    start_burst(0, 0, 3, 1'b0);
    for (i = 0; i < 6; i++) step();
    chk("zero_done_n7", done_o, 1'b1);
    start_burst(1, 1, 0, 1'b0);
    chk("p0_done", done_o, 1'b1);
    chk("p0_busy", busy_o, 1'b0);
    step();

    // Free-run, dropped in a HIGH cycle after 300 pulses
    start_burst(1, 1, 2, 1'b1);
    for (i = 0; i < 1000; i++) begin
      if (m_pulses >= 300 && e_clk) break;
      step();
    end
    chk("fr_reach", (i < 1000), 1'b1);
    free_run_i = 1'b0;
    run_until_done("fr", 10);
    chk("fr_done", done_o, 1'b1);
    chk("fr_pc", pulse_cnt_o, 8'd45);

    // Ignored restart at pulse 2, abort at pulse 5
    start_burst(2, 2, 10, 1'b0);
    for (i = 0; i < 100 && !(m_pulses == 1 && e_clk); i++) step();
    start_i = 1'b1; high_cnt_i = 8'd7; step(); start_i = 1'b0;
    for (i = 0; i < 100 && !(m_pulses == 4 && e_clk); i++) step();
    abort_i = 1'b1; step(); abort_i = 1'b0;
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_pc", pulse_cnt_o, 8'd4);
    for (i = 0; i < 4; i++) step();

    // Mid-burst changes, then start in the done cycle
    start_burst(3, 1, 3, 1'b0);
    step();
    high_cnt_i = 8'd7; low_cnt_i = 8'd5; burst_len_i = 8'd9;
    run_until_done("mid", 40);
    chk("mid_pc", pulse_cnt_o, 8'd3);
    start_burst(1, 2, 2, 1'b0);
    chk("b2b_clk", clk_o, 1'b1);
    run_until_done("b2b", 20);

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      start_i = ($urandom % 6 == 0);
      abort_i = ($urandom % 97 == 0);
      if ($urandom % 40 == 0) free_run_i = ~free_run_i;
      if ($urandom % 4 == 0) begin
        high_cnt_i = 8'($urandom % 4);
        low_cnt_i = 8'($urandom % 4);
        burst_len_i = 8'($urandom % 6);
      end
      en_i = $urandom % 2;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
